// File: rtl/gearbox_downsizing_2x.sv
// Splits each 2*nb-bit input word into two nb-bit output beats, low half first.
// Latency: low half is presented the cycle after the word is accepted; high half follows on the next output transfer.
// Backpressure: out_tready stalls both beats; in_tready is 1 in EMPTY, or in HI when the high half is leaving this cycle.
module gearbox_downsizing_2x #(
    parameter int n  = 5,
    parameter int nb = n * 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [2*nb-1:0]   in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [nb-1:0]     out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2
    } state_t;

    state_t            state;
    logic [2*nb-1:0]   hold_dat;
    logic              in_xfer;
    logic              out_xfer;

    // A new word may enter while the high half drains, giving one beat per cycle.
    assign in_tready = (state == EMPTY) || ((state == HI) && out_tready);
    assign in_xfer   = in_tvalid && in_tready;
    assign out_xfer  = out_tvalid && out_tready;

    // Outputs decode only from state and the holding register, never from inputs.
    assign out_tvalid = (state != EMPTY);
    assign out_tdata  = (state == HI) ? hold_dat[2*nb-1:nb] : hold_dat[nb-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= EMPTY;
            hold_dat <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        hold_dat <= in_tdata;
                        state    <= LO;
                    end
                end
                LO: begin
                    if (out_xfer) begin
                        state <= HI;
                    end
                end
                HI: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            hold_dat <= in_tdata;
                            state    <= LO;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule
